// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one 32-bit bitwise logic unit between two requesters.
// A granted request runs IDLE -> EXEC -> DONE; DONE pulses ACK/VALID for one cycle.
module logic_unit_arbiter #(
    parameter int unsigned RR_INIT   = 0,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ0,
    input  logic [1:0]           OP0,
    input  logic [31:0]          A0,
    input  logic [31:0]          B0,
    input  logic                 REQ1,
    input  logic [1:0]           OP1,
    input  logic [31:0]          A1,
    input  logic [31:0]          B1,
    output logic                 ACK0,
    output logic                 ACK1,
    output logic [31:0]          Y,
    output logic                 VALID,
    output logic [1:0]           GNT,
    output logic                 BUSY,
    output logic [CNT_WIDTH-1:0] OPS
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic PTR_INIT = (RR_INIT != 0);

    state_t               state_q, state_d;
    logic                 ptr_q, ptr_d;
    logic [1:0]           gnt_q, gnt_d;
    logic [1:0]           op_q, op_d;
    logic [31:0]          a_q, a_d;
    logic [31:0]          b_q, b_d;
    logic [31:0]          y_q, y_d;
    logic [CNT_WIDTH-1:0] ops_q, ops_d;
    logic                 sel;

    function automatic logic [31:0] logic_op(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a | b);
            default: return ~a;
        endcase
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= PTR_INIT;
            gnt_q   <= 2'b00;
            op_q    <= 2'b00;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            y_q     <= 32'd0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            ops_q   <= ops_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        ops_d   = ops_q;
        sel     = 1'b0;
        case (state_q)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    // On a tie the pointer decides; either way priority passes to the loser.
                    sel     = (REQ0 && REQ1) ? ptr_q : REQ1;
                    ptr_d   = ~sel;
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    op_d    = sel ? OP1 : OP0;
                    a_d     = sel ? A1  : A0;
                    b_d     = sel ? B1  : B0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                y_d     = logic_op(op_q, a_q, b_q);
                ops_d   = ops_q + 1'b1;
                state_d = DONE;
            end
            DONE: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    assign ACK0  = (state_q == DONE) && gnt_q[0];
    assign ACK1  = (state_q == DONE) && gnt_q[1];
    assign VALID = (state_q == DONE);
    assign BUSY  = (state_q != IDLE);
    assign GNT   = gnt_q;
    assign Y     = y_q;
    assign OPS   = ops_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: a default instance plus a 4-bit-counter
// instance driven by the same requesters to exercise OPS wrap-around.
module tb_logic_unit_arbiter;

    logic        CLK, RST;
    logic        REQ0, REQ1;
    logic [1:0]  OP0, OP1;
    logic [31:0] A0, B0, A1, B1;

    logic        ACK0, ACK1, VALID, BUSY;
    logic [31:0] Y;
    logic [1:0]  GNT;
    logic [15:0] OPS;

    logic        ACK0_4, ACK1_4, VALID_4, BUSY_4;
    logic [31:0] Y_4;
    logic [1:0]  GNT_4;
    logic [3:0]  OPS_4;

    int checks = 0;
    int errors = 0;
    int exp_ops = 0;

    logic_unit_arbiter #(.RR_INIT(0), .CNT_WIDTH(16)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .OP0(OP0), .A0(A0), .B0(B0),
        .REQ1(REQ1), .OP1(OP1), .A1(A1), .B1(B1),
        .ACK0(ACK0), .ACK1(ACK1), .Y(Y), .VALID(VALID),
        .GNT(GNT), .BUSY(BUSY), .OPS(OPS)
    );

    logic_unit_arbiter #(.RR_INIT(0), .CNT_WIDTH(4)) dut4 (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .OP0(OP0), .A0(A0), .B0(B0),
        .REQ1(REQ1), .OP1(OP1), .A1(A1), .B1(B1),
        .ACK0(ACK0_4), .ACK1(ACK1_4), .Y(Y_4), .VALID(VALID_4),
        .GNT(GNT_4), .BUSY(BUSY_4), .OPS(OPS_4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One uncontended operation from requester n, checked through EXEC, DONE and back to IDLE.
    task automatic run_single(input bit n, input logic [1:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_y);
        if (!n) begin REQ0 = 1'b1; OP0 = op; A0 = a; B0 = b; end
        else    begin REQ1 = 1'b1; OP1 = op; A1 = a; B1 = b; end
        step();
        chk("gnt_exec", {30'd0, GNT}, n ? 32'd2 : 32'd1);
        chk("busy_exec", {31'd0, BUSY}, 32'd1);
        step();
        exp_ops++;
        chk("ack_own", {31'd0, n ? ACK1 : ACK0}, 32'd1);
        chk("ack_other", {31'd0, n ? ACK0 : ACK1}, 32'd0);
        chk("valid_done", {31'd0, VALID}, 32'd1);
        chk("y_done", Y, exp_y);
        chk("ops16", {16'd0, OPS}, exp_ops & 32'hFFFF);
        chk("ops4", {28'd0, OPS_4}, exp_ops & 32'hF);
        if (!n) REQ0 = 1'b0; else REQ1 = 1'b0;
        step();
        chk("ack_drop", {30'd0, ACK1, ACK0}, 32'd0);
        chk("valid_drop", {31'd0, VALID}, 32'd0);
        chk("gnt_idle", {30'd0, GNT}, 32'd0);
        chk("busy_idle", {31'd0, BUSY}, 32'd0);
        chk("y_hold", Y, exp_y);
    endtask

    initial begin
        RST = 1'b1;
        REQ0 = 1'b0; OP0 = 2'b00; A0 = 32'd0; B0 = 32'd0;
        REQ1 = 1'b0; OP1 = 2'b00; A1 = 32'd0; B1 = 32'd0;
        #2;
        chk("rst_y", Y, 32'd0);
        chk("rst_ops", {16'd0, OPS}, 32'd0);
        chk("rst_gnt", {30'd0, GNT}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_ack_valid", {29'd0, ACK1, ACK0, VALID}, 32'd0);
        step();
        step();
        RST = 1'b0;

        // Tie with pointer at requester 0: 0 first (OR), then 1 (NOR) three cycles later.
        REQ0 = 1'b1; OP0 = 2'b01; A0 = 32'h0000000F; B0 = 32'h000000F0;
        REQ1 = 1'b1; OP1 = 2'b10; A1 = 32'h00000000; B1 = 32'h00000000;
        step();
        chk("tie_gnt0", {30'd0, GNT}, 32'd1);
        step();
        exp_ops++;
        chk("tie_ack0", {30'd0, ACK1, ACK0}, 32'd1);
        chk("tie_y0", Y, 32'h000000FF);
        chk("tie_ops1", {16'd0, OPS}, 32'd1);
        REQ0 = 1'b0;
        step();
        chk("tie_idle", {30'd0, ACK1, ACK0}, 32'd0);
        chk("tie_busy_idle", {31'd0, BUSY}, 32'd0);
        step();
        chk("tie_gnt1", {30'd0, GNT}, 32'd2);
        step();
        exp_ops++;
        chk("tie_ack1", {30'd0, ACK1, ACK0}, 32'd2);
        chk("tie_y1", Y, 32'hFFFFFFFF);
        chk("tie_ops2", {16'd0, OPS}, 32'd2);
        REQ1 = 1'b0;
        step();

        // Requester 0 alone: AND.
        run_single(1'b0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
        // Requester 1 alone: INV ignores B.
        run_single(1'b1, 2'b11, 32'h0000FFFF, 32'h12345678, 32'hFFFF0000);

        // Tie after requester 1 was served goes to requester 0; A0 changes during EXEC.
        REQ0 = 1'b1; OP0 = 2'b00; A0 = 32'h0000FFFF; B0 = 32'hFFFFFFFF;
        REQ1 = 1'b1; OP1 = 2'b11; A1 = 32'h0000FFFF; B1 = 32'h00000000;
        step();
        chk("ptr_gnt0", {30'd0, GNT}, 32'd1);
        A0 = 32'hFFFFFFFF;
        step();
        exp_ops++;
        chk("late_ack0", {30'd0, ACK1, ACK0}, 32'd1);
        chk("late_y", Y, 32'h0000FFFF);
        REQ0 = 1'b0;
        step();
        step();
        chk("ptr_gnt1", {30'd0, GNT}, 32'd2);
        step();
        exp_ops++;
        chk("ptr_ack1", {30'd0, ACK1, ACK0}, 32'd2);
        chk("ptr_y1", Y, 32'hFFFF0000);
        chk("ptr_ops", {16'd0, OPS}, 32'd6);
        REQ1 = 1'b0;
        step();

        // Reset while in EXEC: outputs return to reset values without waiting for an edge.
        REQ0 = 1'b1; OP0 = 2'b01; A0 = 32'h12345678; B0 = 32'h0;
        step();
        chk("mid_busy", {31'd0, BUSY}, 32'd1);
        RST = 1'b1;
        #1;
        chk("mid_busy_rst", {31'd0, BUSY}, 32'd0);
        chk("mid_gnt_rst", {30'd0, GNT}, 32'd0);
        chk("mid_y_rst", Y, 32'd0);
        chk("mid_ops_rst", {16'd0, OPS}, 32'd0);
        chk("mid_ack_rst", {29'd0, ACK1, ACK0, VALID}, 32'd0);
        REQ0 = 1'b0;
        step();
        chk("mid_no_ack", {29'd0, ACK1, ACK0, VALID}, 32'd0);
        RST = 1'b0;
        exp_ops = 0;
        step();

        // Sixteen operations: the 4-bit counter reads 15 then wraps to 0.
        for (int i = 1; i <= 16; i++) begin
            logic [31:0] a, b;
            a = i;
            b = a << 4;
            run_single(1'b0, 2'b01, a, b, a | b);
        end
        chk("wrap_ops4", {28'd0, OPS_4}, 32'd0);
        chk("wrap_ops16", {16'd0, OPS}, 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
